// File: rtl/data_line_sequencer.sv
// data_line_sequencer: takes decoded data opcodes (+ - > < . ,) over a
// valid/ready handshake. It owns the data pointer and drives the one-cycle
// strobes to the cell counter, the data memory and the console. A pointer move
// or an output writes a modified cell back to memory first (STORE), and ','
// holds here until a keyboard character is available.
//
// Handshake: an opcode is taken at a rising edge where op_valid_i and
// op_ready_o are both high. op_ready_o depends on the current state only
// (high exactly in IDLE), so it never combinationally depends on op_valid_i.
// While busy_o is high, op_i and op_valid_i are ignored.
module data_line_sequencer #(
    parameter int          ADDRESS_WIDTH = 16,
    parameter int unsigned MAX_ADDRESS   = 29999
) (
    input  logic                     clock_i,
    input  logic                     rst_i,
    input  logic [2:0]               op_i,
    input  logic                     op_valid_i,
    output logic                     op_ready_o,
    input  logic                     key_valid_i,
    output logic [ADDRESS_WIDTH-1:0] address_o,
    output logic                     load_o,
    output logic                     store_o,
    output logic                     inc_o,
    output logic                     dec_o,
    output logic                     in_o,
    output logic                     out_o,
    output logic                     busy_o,
    output logic [2:0]               state_o
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_CELL = ADDRESS_WIDTH'(MAX_ADDRESS);

    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_DEC   = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;
    localparam logic [2:0] OP_LEFT  = 3'd4;
    localparam logic [2:0] OP_OUT   = 3'd5;
    localparam logic [2:0] OP_IN    = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE_MV  = 3'd1,
        LOAD_MV   = 3'd2,
        STORE_OUT = 3'd3,
        OUT_P     = 3'd4,
        WAIT_KEY  = 3'd5
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic                     dirty_q, dirty_d;   // counter holds a value newer than RAM
    logic                     dir_q, dir_d;       // 1 = pending move is RIGHT
    logic                     load_q, load_d;
    logic                     store_q, store_d;
    logic                     inc_q, inc_d;
    logic                     dec_q, dec_d;
    logic                     in_q, in_d;
    logic                     out_q, out_d;

    // Neighbouring cell with wrap-around at both ends of the tape.
    function automatic logic [ADDRESS_WIDTH-1:0] next_addr(
        input logic [ADDRESS_WIDTH-1:0] a,
        input logic                     right
    );
        if (right) begin
            next_addr = (a == LAST_CELL) ? '0 : a + ADDRESS_WIDTH'(1);
        end else begin
            next_addr = (a == '0) ? LAST_CELL : a - ADDRESS_WIDTH'(1);
        end
    endfunction

    // Next-state, pointer, dirty flag and strobe decisions.
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        dirty_d   = dirty_q;
        dir_d     = dir_q;
        load_d    = 1'b0;
        store_d   = 1'b0;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        in_d      = 1'b0;
        out_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    case (op_i)
                        OP_INC: begin
                            inc_d   = 1'b1;
                            dirty_d = 1'b1;
                        end
                        OP_DEC: begin
                            dec_d   = 1'b1;
                            dirty_d = 1'b1;
                        end
                        OP_RIGHT, OP_LEFT: begin
                            dir_d = (op_i == OP_RIGHT);
                            if (dirty_q) begin
                                // Write the cell back before leaving it.
                                store_d = 1'b1;
                                dirty_d = 1'b0;
                                state_d = STORE_MV;
                            end else begin
                                // Clean cell: move immediately and reload.
                                address_d = next_addr(address_q, op_i == OP_RIGHT);
                                load_d    = 1'b1;
                                state_d   = LOAD_MV;
                            end
                        end
                        OP_OUT: begin
                            if (dirty_q) begin
                                store_d = 1'b1;
                                dirty_d = 1'b0;
                                state_d = STORE_OUT;
                            end else begin
                                out_d   = 1'b1;
                                state_d = OUT_P;
                            end
                        end
                        OP_IN: begin
                            state_d = WAIT_KEY;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            STORE_MV: begin
                address_d = next_addr(address_q, dir_q);
                load_d    = 1'b1;
                state_d   = LOAD_MV;
            end
            LOAD_MV: begin
                state_d = IDLE;
            end
            STORE_OUT: begin
                out_d   = 1'b1;
                state_d = OUT_P;
            end
            OUT_P: begin
                state_d = IDLE;
            end
            WAIT_KEY: begin
                if (key_valid_i) begin
                    in_d    = 1'b1;
                    dirty_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and registered strobes; reset overrides everything.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            address_q <= '0;
            dirty_q   <= 1'b0;
            dir_q     <= 1'b0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            in_q      <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            dirty_q   <= dirty_d;
            dir_q     <= dir_d;
            load_q    <= load_d;
            store_q   <= store_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            in_q      <= in_d;
            out_q     <= out_d;
        end
    end

    assign op_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);
    assign address_o  = address_q;
    assign load_o     = load_q;
    assign store_o    = store_q;
    assign inc_o      = inc_q;
    assign dec_o      = dec_q;
    assign in_o       = in_q;
    assign out_o      = out_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_data_line_sequencer.sv
// Directed bench for data_line_sequencer: a per-cycle vector table with
// hand-computed outputs, followed by a few hand-written multi-cycle sequences.
module tb_data_line_sequencer;

    // Strobe pattern order: {load, store, inc, dec, in, out}
    localparam logic [5:0] S_NONE  = 6'b000000;
    localparam logic [5:0] S_LOAD  = 6'b100000;
    localparam logic [5:0] S_STORE = 6'b010000;
    localparam logic [5:0] S_INC   = 6'b001000;
    localparam logic [5:0] S_DEC   = 6'b000100;
    localparam logic [5:0] S_IN    = 6'b000010;
    localparam logic [5:0] S_OUT   = 6'b000001;

    logic        clock_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  op_i = 3'd0;
    logic        op_valid_i = 1'b0;
    logic        key_valid_i = 1'b0;
    logic        op_ready_o;
    logic [15:0] address_o;
    logic        load_o, store_o, inc_o, dec_o, in_o, out_o;
    logic        busy_o;
    logic [2:0]  state_o;

    int n_cmp = 0;
    int n_err = 0;

    data_line_sequencer dut (
        .clock_i     (clock_i),
        .rst_i       (rst_i),
        .op_i        (op_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .key_valid_i (key_valid_i),
        .address_o   (address_o),
        .load_o      (load_o),
        .store_o     (store_o),
        .inc_o       (inc_o),
        .dec_o       (dec_o),
        .in_o        (in_o),
        .out_o       (out_o),
        .busy_o      (busy_o),
        .state_o     (state_o)
    );

    // Clock and reset
    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        rst;
        logic [2:0]  op;
        logic        valid;
        logic        key;
        logic        exp_ready;
        logic        exp_busy;
        logic [15:0] exp_addr;
        logic [5:0]  exp_strb;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] strobes();
        return {load_o, store_o, inc_o, dec_o, in_o, out_o};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] op, input logic v, input logic k,
                       input logic rdy, input logic bsy, input logic [15:0] a,
                       input logic [5:0] s);
        vec_t t;
        t.rst = r; t.op = op; t.valid = v; t.key = k;
        t.exp_ready = rdy; t.exp_busy = bsy; t.exp_addr = a; t.exp_strb = s;
        vecs.push_back(t);
    endtask

    // Driver: apply inputs on the falling edge, then let one rising edge pass.
    task automatic drive(input logic r, input logic [2:0] op, input logic v, input logic k);
        @(negedge clock_i);
        rst_i = r; op_i = op; op_valid_i = v; key_valid_i = k;
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_outputs(input int idx, input logic rdy, input logic bsy,
                                 input logic [15:0] a, input logic [5:0] s);
        check("op_ready", idx, 32'(op_ready_o), 32'(rdy));
        check("busy", idx, 32'(busy_o), 32'(bsy));
        check("address", idx, 32'(address_o), 32'(a));
        check("strobes", idx, 32'(strobes()), 32'(s));
        check("one_hot_strobe", idx, 32'($countones(strobes()) <= 1), 32'd1);
    endtask

    initial begin
        // Reset, then reset again while parked in WAIT_KEY
        add(1, 0, 0, 0, 1, 0, 0, S_NONE);
        add(1, 0, 0, 0, 1, 0, 0, S_NONE);
        add(0, 6, 1, 0, 0, 1, 0, S_NONE);
        add(1, 0, 0, 0, 1, 0, 0, S_NONE);
        add(1, 0, 0, 1, 1, 0, 0, S_NONE);
        add(0, 0, 0, 1, 1, 0, 0, S_NONE);      // key outside WAIT_KEY ignored
        // INC x3 back-to-back, then a dirty RIGHT
        add(0, 1, 1, 0, 1, 0, 0, S_INC);
        add(0, 1, 1, 0, 1, 0, 0, S_INC);
        add(0, 1, 1, 0, 1, 0, 0, S_INC);
        add(0, 3, 1, 0, 0, 1, 0, S_STORE);
        add(0, 1, 1, 0, 0, 1, 1, S_LOAD);      // INC while busy ignored
        add(0, 0, 0, 0, 1, 0, 1, S_NONE);
        // Clean moves and wrap at both ends
        add(0, 4, 1, 0, 0, 1, 0, S_LOAD);
        add(0, 0, 0, 0, 1, 0, 0, S_NONE);
        add(0, 4, 1, 0, 0, 1, 29999, S_LOAD);
        add(0, 0, 0, 0, 1, 0, 29999, S_NONE);
        add(0, 3, 1, 0, 0, 1, 0, S_LOAD);
        add(0, 0, 0, 0, 1, 0, 0, S_NONE);
        // DEC then OUT (dirty), then a clean OUT
        add(0, 2, 1, 0, 1, 0, 0, S_DEC);
        add(0, 5, 1, 0, 0, 1, 0, S_STORE);
        add(0, 5, 1, 0, 0, 1, 0, S_OUT);
        add(0, 5, 1, 0, 1, 0, 0, S_NONE);      // still busy at that edge
        add(0, 5, 1, 0, 0, 1, 0, S_OUT);
        add(0, 0, 0, 0, 1, 0, 0, S_NONE);
        // IN with the key held off, then the key, then a RIGHT that must STORE
        add(0, 6, 1, 0, 0, 1, 0, S_NONE);
        for (int i = 0; i < 5; i++) add(0, 3'(1 + i), 1, 0, 0, 1, 0, S_NONE);
        add(0, 0, 0, 1, 1, 0, 0, S_IN);
        add(0, 3, 1, 0, 0, 1, 0, S_STORE);
        add(0, 0, 0, 0, 0, 1, 1, S_LOAD);
        add(0, 0, 0, 0, 1, 0, 1, S_NONE);
        // Opcode 7/0 never strobe; ops changing while busy are dropped
        add(0, 7, 1, 0, 1, 0, 1, S_NONE);
        add(0, 7, 1, 0, 1, 0, 1, S_NONE);
        add(0, 0, 1, 0, 1, 0, 1, S_NONE);
        add(0, 1, 1, 0, 1, 0, 1, S_INC);
        add(0, 5, 1, 0, 0, 1, 1, S_STORE);
        add(0, 3, 1, 0, 0, 1, 1, S_OUT);
        add(0, 4, 1, 0, 1, 0, 1, S_NONE);
        add(0, 7, 1, 0, 1, 0, 1, S_NONE);
        // Reset mid-move clears DIRTY and the pointer; nothing resumes
        add(0, 2, 1, 0, 1, 0, 1, S_DEC);
        add(0, 4, 1, 0, 0, 1, 1, S_STORE);
        add(1, 4, 1, 0, 1, 0, 0, S_NONE);
        add(0, 0, 0, 0, 1, 0, 0, S_NONE);
        add(0, 3, 1, 0, 0, 1, 1, S_LOAD);      // clean after reset: no STORE
        add(0, 0, 0, 0, 1, 0, 1, S_NONE);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].valid, vecs[i].key);
            check_outputs(i, vecs[i].exp_ready, vecs[i].exp_busy, vecs[i].exp_addr,
                          vecs[i].exp_strb);
        end

        // Hand sequence: long key wait with a bounded wait for the IN pulse
        begin
            int  waits;
            bit  seen;
            drive(0, 6, 1, 0);
            check_outputs(1000, 0, 1, 1, S_NONE);
            waits = $urandom_range(8, 3);
            for (int i = 0; i < waits; i++) begin
                drive(0, 3'(i), 1, 0);
                check_outputs(1001 + i, 0, 1, 1, S_NONE);
            end
            seen = 0;
            @(negedge clock_i);
            op_valid_i = 0; key_valid_i = 1;
            for (int i = 0; i < 4 && !seen; i++) begin
                @(posedge clock_i);
                #1;
                if (in_o) seen = 1;
                @(negedge clock_i);
                key_valid_i = 0;
            end
            check("in_pulse_seen", 1100, 32'(seen), 32'd1);
            check("ready_after_in", 1101, 32'(op_ready_o), 32'd1);
            drive(0, 0, 0, 0);
            check("in_single_pulse", 1102, 32'(in_o), 32'd0);
            // IN left the cell dirty: a LEFT writes back at 1 then loads 0
            drive(0, 4, 1, 0);
            check_outputs(1103, 0, 1, 1, S_STORE);
            drive(0, 0, 0, 0);
            check_outputs(1104, 0, 1, 0, S_LOAD);
            drive(0, 0, 0, 0);
            check_outputs(1105, 1, 0, 0, S_NONE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
